// File: rtl/usp_axis256_to_512_packer_if.sv
// usp_axis256_to_512_packer_if
//   Bus bundle for the 256-to-512 capture packer, plus the shared 512-bit
//   beat type used by the capture viewer.
//
//   Signals:
//     s_tdata  [255:0]  input beat data, dword 0 in bits [31:0]
//     s_tkeep  [7:0]    per-dword keep for s_tdata
//     s_tlast           last beat of packet
//     s_tvalid          beat valid; there is no ready
//     dout              packed 512-bit output beat (axis512_t)
//
//   Modports:
//     master  drives the 256-bit input stream and observes dout
//     slave   consumes the 256-bit input stream and drives dout

package bitables_pkg;

  // One 512-bit capture beat; keep is per 32-bit dword.
  typedef struct packed {
    logic [511:0] tdata;
    logic [15:0]  tkeep;
    logic         tlast;
    logic         tvalid;
  } axis512_t;

endpackage

interface usp_axis256_to_512_packer_if;

  logic [255:0]          s_tdata;
  logic [7:0]            s_tkeep;
  logic                  s_tlast;
  logic                  s_tvalid;
  bitables_pkg::axis512_t dout;

  modport master (
    output s_tdata,
    output s_tkeep,
    output s_tlast,
    output s_tvalid,
    input  dout
  );

  modport slave (
    input  s_tdata,
    input  s_tkeep,
    input  s_tlast,
    input  s_tvalid,
    output dout
  );

endinterface

// File: rtl/usp_axis256_to_512_packer.sv
// usp_axis256_to_512_packer
//   Packs consecutive 256-bit valid-only AXI-Stream beats into 512-bit beats
//   for the capture viewer. A packet's final beat is emitted on its own
//   (upper half zero) when it lands in the lower half. Malformed keep masks
//   are counted and flagged but the data is always forwarded unmodified.
//
//   Ports:
//     clk           sole clock
//     srst          synchronous active-high reset
//     bus           slave side of usp_axis256_to_512_packer_if
//                   (s_tdata/s_tkeep/s_tlast/s_tvalid in, dout out)
//     pkt_cnt       output beats with tlast=1, wrapping
//     keep_err_cnt  malformed-keep input beats, saturating at all-ones
//     keep_err      sticky keep-error flag, cleared only by srst

module usp_axis256_to_512_packer #(
  parameter int CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      srst,
  usp_axis256_to_512_packer_if.slave bus,
  output logic [CNT_BITS-1:0]       pkt_cnt,
  output logic [CNT_BITS-1:0]       keep_err_cnt,
  output logic                      keep_err
);

  typedef enum logic {
    LO_STA,
    HI_STA
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [255:0]  hold_data;
  logic [7:0]    hold_keep;

  logic          capture;
  logic          emit;
  logic [511:0]  emit_data;
  logic [15:0]   emit_keep;
  logic          emit_last;
  logic          keep_bad;

  logic [511:0]  dout_tdata;
  logic [15:0]   dout_tkeep;
  logic          dout_tlast;
  logic          dout_tvalid;

  assign bus.dout.tdata  = dout_tdata;
  assign bus.dout.tkeep  = dout_tkeep;
  assign bus.dout.tlast  = dout_tlast;
  assign bus.dout.tvalid = dout_tvalid;

  // State register. Reset always returns to LO_STA, which silently drops
  // any half that was being held.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= LO_STA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and packing decision. In LO_STA a non-last beat is parked
  // as the lower half; a last beat goes straight out with a zero upper
  // half. In HI_STA any valid beat completes the 512-bit word.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    emit      = 1'b0;
    emit_data = {256'h0, bus.s_tdata};
    emit_keep = {8'h00, bus.s_tkeep};
    emit_last = bus.s_tlast;
    case (state_q)
      LO_STA: begin
        if (bus.s_tvalid) begin
          if (bus.s_tlast) begin
            emit = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = HI_STA;
          end
        end
      end
      HI_STA: begin
        if (bus.s_tvalid) begin
          emit      = 1'b1;
          emit_data = {bus.s_tdata, hold_data};
          emit_keep = {bus.s_tkeep, hold_keep};
          state_d   = LO_STA;
        end
      end
      default: begin
        state_d = LO_STA;
      end
    endcase
  end

  // Keep legality. Non-last beats must be full. A last beat must be a
  // nonzero run of ones starting at dword 0; such a mask plus one is a
  // power of two (or wraps to zero for 8'hFF), so AND-ing the two is zero.
  always_comb begin
    keep_bad = 1'b0;
    if (bus.s_tvalid) begin
      if (bus.s_tlast) begin
        keep_bad = (bus.s_tkeep == 8'h00) ||
                   ((bus.s_tkeep & (bus.s_tkeep + 8'd1)) != 8'h00);
      end else begin
        keep_bad = (bus.s_tkeep != 8'hFF);
      end
    end
  end

  // Lower-half holding registers. Only loaded when a half is parked; they
  // keep stale contents otherwise, which is harmless because HI_STA is the
  // only state that reads them.
  always_ff @(posedge clk) begin
    if (srst) begin
      hold_data <= '0;
      hold_keep <= '0;
    end else if (capture) begin
      hold_data <= bus.s_tdata;
      hold_keep <= bus.s_tkeep;
    end
  end

  // Registered output beat. tvalid is a single-cycle pulse; the payload
  // fields keep their last values between pulses.
  always_ff @(posedge clk) begin
    if (srst) begin
      dout_tdata  <= '0;
      dout_tkeep  <= '0;
      dout_tlast  <= 1'b0;
      dout_tvalid <= 1'b0;
    end else begin
      dout_tvalid <= emit;
      if (emit) begin
        dout_tdata <= emit_data;
        dout_tkeep <= emit_keep;
        dout_tlast <= emit_last;
      end
    end
  end

  // Statistics. The packet counter wraps freely; the keep-error counter
  // sticks at all-ones so a flood of bad beats never reads back as small.
  always_ff @(posedge clk) begin
    if (srst) begin
      pkt_cnt      <= '0;
      keep_err_cnt <= '0;
      keep_err     <= 1'b0;
    end else begin
      if (emit && emit_last) begin
        pkt_cnt <= pkt_cnt + CNT_BITS'(1);
      end
      if (keep_bad) begin
        keep_err <= 1'b1;
        if (keep_err_cnt != '1) begin
          keep_err_cnt <= keep_err_cnt + CNT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_usp_axis256_to_512_packer.sv
// tb_usp_axis256_to_512_packer
//   Bench for the 256-to-512 capture packer. Two instances share the same
//   stimulus: one with 16-bit statistics and one with 2-bit statistics so
//   wrap and saturation are reachable in a few beats.

module tb_usp_axis256_to_512_packer;

  logic clk = 1'b0;
  logic srst = 1'b1;

  logic [15:0] pkt16;
  logic [15:0] kerr16;
  logic        flag16;
  logic [1:0]  pkt2;
  logic [1:0]  kerr2;
  logic        flag2;

  int n_vec = 0;
  int n_err = 0;

  usp_axis256_to_512_packer_if bus16 ();
  usp_axis256_to_512_packer_if bus2 ();

  usp_axis256_to_512_packer #(.CNT_BITS(16)) dut16 (
    .clk          (clk),
    .srst         (srst),
    .bus          (bus16.slave),
    .pkt_cnt      (pkt16),
    .keep_err_cnt (kerr16),
    .keep_err     (flag16)
  );

  usp_axis256_to_512_packer #(.CNT_BITS(2)) dut2 (
    .clk          (clk),
    .srst         (srst),
    .bus          (bus2.slave),
    .pkt_cnt      (pkt2),
    .keep_err_cnt (kerr2),
    .keep_err     (flag2)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Reference model: a packet is a list of 256-bit beats, and each output
  // word is simply the next two beats of that list, or a lone final beat.
  // Counters are kept as unbounded integers and reduced at compare time.
  logic [255:0] pend_data[$];
  logic [7:0]   pend_keep[$];
  logic         m_vld = 1'b0;
  logic [511:0] m_data = '0;
  logic [15:0]  m_keep = '0;
  logic         m_last = 1'b0;
  int           m_pkt = 0;
  int           m_err = 0;
  logic         m_flag = 1'b0;

  always @(posedge clk) begin
    logic bad;
    m_vld = 1'b0;
    if (srst) begin
      pend_data.delete();
      pend_keep.delete();
      m_data = '0;
      m_keep = '0;
      m_last = 1'b0;
      m_pkt  = 0;
      m_err  = 0;
      m_flag = 1'b0;
    end else if (bus16.s_tvalid) begin
      if (bus16.s_tlast) begin
        bad = !(bus16.s_tkeep inside {8'h01, 8'h03, 8'h07, 8'h0F,
                                      8'h1F, 8'h3F, 8'h7F, 8'hFF});
      end else begin
        bad = (bus16.s_tkeep != 8'hFF);
      end
      if (bad) begin
        m_err++;
        m_flag = 1'b1;
      end
      pend_data.push_back(bus16.s_tdata);
      pend_keep.push_back(bus16.s_tkeep);
      if (bus16.s_tlast || pend_data.size() == 2) begin
        m_vld = 1'b1;
        if (pend_data.size() == 2) begin
          m_data = {pend_data[1], pend_data[0]};
          m_keep = {pend_keep[1], pend_keep[0]};
        end else begin
          m_data = {256'h0, pend_data[0]};
          m_keep = {8'h00, pend_keep[0]};
        end
        m_last = bus16.s_tlast;
        if (bus16.s_tlast) m_pkt++;
        pend_data.delete();
        pend_keep.delete();
      end
    end
  end

  // Recognisable 256-bit half for a given tag; tag 0 means an all-zero half.
  function automatic logic [255:0] half(input logic [7:0] tag);
    logic [255:0] h;
    h = '0;
    if (tag != 8'd0) begin
      for (int d = 0; d < 8; d++) begin
        h[d*32 +: 32] = {8'hA5, tag, 8'(d), 8'h5A};
      end
    end
    return h;
  endfunction

  task automatic cmp(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one input cycle onto both instances and advances past the edge.
  task automatic applyStimulus(input logic rst, input logic vld,
                               input logic [255:0] data,
                               input logic [7:0] keep, input logic last);
    srst           = rst;
    bus16.s_tvalid = vld;
    bus16.s_tdata  = data;
    bus16.s_tkeep  = keep;
    bus16.s_tlast  = last;
    bus2.s_tvalid  = vld;
    bus2.s_tdata   = data;
    bus2.s_tkeep   = keep;
    bus2.s_tlast   = last;
    @(posedge clk);
    #1;
  endtask

  // Compares both instances against the reference model.
  task automatic checkOutput();
    cmp("dout_tvalid", bus16.dout.tvalid, m_vld);
    cmp("dout_tdata", bus16.dout.tdata, m_data);
    cmp("dout_tkeep", bus16.dout.tkeep, m_keep);
    cmp("dout_tlast", bus16.dout.tlast, m_last);
    cmp("pkt_cnt16", pkt16, 512'(m_pkt % 65536));
    cmp("keep_err_cnt16", kerr16, 512'((m_err > 65535) ? 65535 : m_err));
    cmp("keep_err16", flag16, m_flag);
    cmp("dout2_tvalid", bus2.dout.tvalid, m_vld);
    cmp("dout2_tdata", bus2.dout.tdata, m_data);
    cmp("pkt_cnt2", pkt2, 512'(m_pkt % 4));
    cmp("keep_err_cnt2", kerr2, 512'((m_err > 3) ? 3 : m_err));
    cmp("keep_err2", flag2, m_flag);
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  tag;
    logic [7:0]  keep;
    logic        last;
    logic        e_vld;
    logic [7:0]  e_lo;
    logic [7:0]  e_hi;
    logic [15:0] e_keep;
    logic        e_last;
    int          e_pkt;
    int          e_kerr;
    logic        e_flag;
  } vec_t;

  vec_t tbl[17];

  // Main test sequence.
  initial begin
    logic [255:0] rdata;
    logic [7:0]   rkeep;
    logic         rrst;
    logic         rvld;
    logic         rlast;

    // rst vld tag keep last | e_vld e_lo e_hi e_keep e_last e_pkt e_kerr e_flag
    tbl[0]  = '{1'b0, 1'b1, 8'd1,  8'hFF, 1'b0, 1'b0, 8'd0,  8'd0,  16'h0000, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'd2,  8'hFF, 1'b0, 1'b1, 8'd1,  8'd2,  16'hFFFF, 1'b0, 0, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'd3,  8'hFF, 1'b0, 1'b0, 8'd0,  8'd0,  16'h0000, 1'b0, 0, 0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'd4,  8'hFF, 1'b1, 1'b1, 8'd3,  8'd4,  16'hFFFF, 1'b1, 1, 0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'd0,  8'h00, 1'b0, 1'b0, 8'd0,  8'd0,  16'h0000, 1'b0, 1, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'd5,  8'h0F, 1'b1, 1'b1, 8'd5,  8'd0,  16'h000F, 1'b1, 2, 0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'd6,  8'hFF, 1'b0, 1'b0, 8'd0,  8'd0,  16'h0000, 1'b0, 2, 0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'd7,  8'hFF, 1'b0, 1'b1, 8'd6,  8'd7,  16'hFFFF, 1'b0, 2, 0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'd8,  8'h07, 1'b1, 1'b1, 8'd8,  8'd0,  16'h0007, 1'b1, 3, 0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'd9,  8'hFF, 1'b1, 1'b1, 8'd9,  8'd0,  16'h00FF, 1'b1, 4, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'd10, 8'h7F, 1'b0, 1'b0, 8'd0,  8'd0,  16'h0000, 1'b0, 4, 1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 8'd11, 8'h05, 1'b1, 1'b1, 8'd10, 8'd11, 16'h057F, 1'b1, 5, 2, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 8'd12, 8'hFF, 1'b0, 1'b0, 8'd0,  8'd0,  16'h0000, 1'b0, 5, 2, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 8'd13, 8'hFF, 1'b0, 1'b0, 8'd0,  8'd0,  16'h0000, 1'b0, 0, 0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 8'd14, 8'hFF, 1'b0, 1'b0, 8'd0,  8'd0,  16'h0000, 1'b0, 0, 0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 8'd15, 8'hFF, 1'b1, 1'b1, 8'd14, 8'd15, 16'hFFFF, 1'b1, 1, 0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 8'd0,  8'h00, 1'b0, 1'b0, 8'd0,  8'd0,  16'h0000, 1'b0, 1, 0, 1'b0};

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, '0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 8'h00, 1'b0);
    cmp("reset_dout", bus16.dout, '0);
    cmp("reset_pkt_cnt", pkt16, 0);
    cmp("reset_keep_err_cnt", kerr16, 0);
    cmp("reset_keep_err", flag16, 0);
    checkOutput();

    $display("[TB] table vectors");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].vld, half(tbl[i].tag), tbl[i].keep,
                    tbl[i].last);
      checkOutput();
      cmp($sformatf("tbl%0d_tvalid", i), bus16.dout.tvalid, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        cmp($sformatf("tbl%0d_tdata", i), bus16.dout.tdata,
            {half(tbl[i].e_hi), half(tbl[i].e_lo)});
        cmp($sformatf("tbl%0d_tkeep", i), bus16.dout.tkeep, tbl[i].e_keep);
        cmp($sformatf("tbl%0d_tlast", i), bus16.dout.tlast, tbl[i].e_last);
      end
      cmp($sformatf("tbl%0d_pkt_cnt", i), pkt16, 512'(tbl[i].e_pkt));
      cmp($sformatf("tbl%0d_keep_err_cnt", i), kerr16, 512'(tbl[i].e_kerr));
      cmp($sformatf("tbl%0d_keep_err", i), flag16, tbl[i].e_flag);
    end

    $display("[TB] narrow counter wrap and saturation");
    applyStimulus(1'b1, 1'b0, '0, 8'h00, 1'b0);
    checkOutput();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, half(8'(20 + k)), 8'h05, 1'b1);
      checkOutput();
    end
    cmp("wrap_pkt_cnt2", pkt2, 1);
    cmp("sat_keep_err_cnt2", kerr2, 3);
    cmp("keep_err2_set", flag2, 1);
    cmp("pkt_cnt16_after5", pkt16, 5);
    cmp("keep_err_cnt16_after5", kerr16, 5);

    $display("[TB] random traffic");
    applyStimulus(1'b1, 1'b0, '0, 8'h00, 1'b0);
    checkOutput();
    for (int n = 0; n < 3000; n++) begin
      rrst  = ($urandom_range(0, 199) == 0);
      rvld  = ($urandom_range(0, 9) < 7);
      rlast = ($urandom_range(0, 3) == 0);
      for (int d = 0; d < 8; d++) begin
        rdata[d*32 +: 32] = $urandom();
      end
      case ($urandom_range(0, 9))
        0:       rkeep = 8'($urandom());
        default: rkeep = rlast ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
      endcase
      applyStimulus(rrst, rvld, rdata, rkeep, rlast);
      checkOutput();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
